uart_bluetooth_tx: RTL and testbench



---
 rtl/uart_bluetooth_tx_pkg.sv | 22 ++
 rtl/uart_bluetooth_tx_if.sv | 27 ++
 rtl/uart_tx_fifo.sv | 51 +++++
 rtl/uart_bluetooth_tx.sv | 138 +++++++++++++
 tb/tb_uart_bluetooth_tx.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_bluetooth_tx_pkg.sv
// Shared definitions for the Bluetooth UART transmitter.
// The bit timing is kept here so the receiver and transmitter stay matched.
package uart_bluetooth_tx_pkg;

    // Clock cycles per serial bit (clock frequency / baud), shared with the receiver.
    localparam int unsigned UART_CLKS_PER_BIT = 10400;
    localparam int unsigned UART_FIFO_DEPTH   = 8;
    localparam int unsigned CLK_CNT_W         = 17;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        START   = 3'b001,
        DATA    = 3'b010,
        STOP    = 3'b011,
        CLEANUP = 3'b100
    } tx_state_e;

    function automatic logic is_frame_state(input tx_state_e s);
        return (s == START) || (s == DATA) || (s == STOP);
    endfunction

endpackage

// File: rtl/uart_bluetooth_tx_if.sv
// Byte handshake and serial-line bundle between the command logic and the transmitter.
interface uart_bluetooth_tx_if;
    logic       i_TX_DV;
    logic [7:0] i_TX_Byte;
    logic       o_TX_Ready;
    logic       o_TX_Active;
    logic       o_TX_Serial;
    logic       o_TX_Done;

    modport master (
        output i_TX_DV,
        output i_TX_Byte,
        input  o_TX_Ready,
        input  o_TX_Active,
        input  o_TX_Serial,
        input  o_TX_Done
    );

    modport slave (
        input  i_TX_DV,
        input  i_TX_Byte,
        output o_TX_Ready,
        output o_TX_Active,
        output o_TX_Serial,
        output o_TX_Done
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO; dout is valid whenever !empty.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A push while full is dropped even if a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_bluetooth_tx.sv
// 8N1 UART transmitter for the Bluetooth link: queued bytes are serialised LSB first.
//
// state   | meaning
// IDLE    | line high; pop FIFO head into shift register when available
// START   | start bit (low) for CLKS_PER_BIT cycles
// DATA    | data bits 0..7, CLKS_PER_BIT cycles each
// STOP    | stop bit (high) for CLKS_PER_BIT cycles
// CLEANUP | one-cycle done pulse, line high
module uart_bluetooth_tx
    import uart_bluetooth_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = UART_FIFO_DEPTH
) (
    input  logic                i_Clock,
    input  logic                i_Reset_n,
    uart_bluetooth_tx_if.slave  bus
);
    localparam logic [CLK_CNT_W-1:0] CLK_TC = CLK_CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e            state_q, state_d;
    logic [CLK_CNT_W-1:0] clk_count_q, clk_count_d;
    logic [2:0]           bit_index_q, bit_index_d;
    logic [2:0]           next_index;
    logic [7:0]           shift_q, shift_d;
    logic                 serial_q, serial_d;
    logic                 bit_done;

    logic                 fifo_pop;
    logic [7:0]           fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .push      (bus.i_TX_DV),
        .pop       (fifo_pop),
        .din       (bus.i_TX_Byte),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bit_done   = (clk_count_q == CLK_TC);
    assign next_index = bit_index_q + 3'd1;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q     <= IDLE;
            clk_count_q <= '0;
            bit_index_q <= '0;
            shift_q     <= '0;
            serial_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_index_q <= bit_index_d;
            shift_q     <= shift_d;
            serial_q    <= serial_d;
        end
    end

    // serial_d is the level for the next cycle, so the line changes on the same
    // edge as the state and comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        serial_d    = serial_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                serial_d    = 1'b1;
                clk_count_d = '0;
                bit_index_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    serial_d = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_done) begin
                    clk_count_d = '0;
                    serial_d    = shift_q[0];
                    state_d     = DATA;
                end else begin
                    clk_count_d = clk_count_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    clk_count_d = '0;
                    if (bit_index_q == 3'd7) begin
                        serial_d = 1'b1;
                        state_d  = STOP;
                    end else begin
                        bit_index_d = next_index;
                        serial_d    = shift_q[next_index];
                    end
                end else begin
                    clk_count_d = clk_count_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    clk_count_d = '0;
                    serial_d    = 1'b1;
                    state_d     = CLEANUP;
                end else begin
                    clk_count_d = clk_count_q + 1'b1;
                end
            end
            CLEANUP: begin
                serial_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                serial_d    = 1'b1;
                clk_count_d = '0;
                bit_index_d = '0;
                state_d     = IDLE;
            end
        endcase
    end

    assign bus.o_TX_Serial = serial_q;
    assign bus.o_TX_Active = is_frame_state(state_q);
    assign bus.o_TX_Done   = (state_q == CLEANUP);
    assign bus.o_TX_Ready  = !fifo_full;

endmodule

// File: tb/tb_uart_bluetooth_tx.sv
// Scoreboard bench: bytes pushed are queued as expectations and checked by a loopback receiver.
module tb_uart_bluetooth_tx;
    localparam int CPB     = 4;
    localparam int CPB_BIG = 10400;
    localparam int FRAME   = 10 * CPB;

    logic i_Clock   = 1'b0;
    logic i_Reset_n = 1'b0;

    uart_bluetooth_tx_if bus_a ();
    uart_bluetooth_tx_if bus_b ();

    uart_bluetooth_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut_a (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .bus       (bus_a)
    );

    uart_bluetooth_tx #(.CLKS_PER_BIT(CPB_BIG), .FIFO_DEPTH(8)) dut_b (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .bus       (bus_b)
    );

    always #5 i_Clock = ~i_Clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_q[$];

    // Loopback receiver / frame monitor for dut_a, sampled on the falling edge.
    int         cyc          = 0;
    bit         rx_busy      = 1'b0;
    bit         rx_chk_done  = 1'b0;
    int         rx_pos       = 0;
    int         rx_wave_err  = 0;
    int         rx_act       = 0;
    logic [7:0] rx_exp       = 8'h00;
    logic [7:0] rx_byte      = 8'h00;
    int         frames       = 0;
    int         done_pulses  = 0;
    int         last_done_cyc = 0;
    int         start_cyc    = 0;
    int         end_cyc      = -100;
    int         gap_last     = -1;

    always @(negedge i_Clock) begin
        int  k;
        logic exp_bit;
        cyc++;
        if (bus_a.o_TX_Done) begin
            done_pulses++;
            last_done_cyc = cyc;
        end
        if (!i_Reset_n) begin
            rx_busy     = 1'b0;
            rx_chk_done = 1'b0;
        end else begin
            if (rx_chk_done) begin
                check_eq("done_after_stop", bus_a.o_TX_Done, 1);
                check_eq("active_low_in_cleanup", bus_a.o_TX_Active, 0);
                rx_chk_done = 1'b0;
            end
            if (!rx_busy && bus_a.o_TX_Serial == 1'b0) begin
                rx_busy     = 1'b1;
                rx_pos      = 0;
                rx_wave_err = 0;
                rx_act      = 0;
                rx_byte     = 8'h00;
                start_cyc   = cyc;
                gap_last    = cyc - end_cyc - 1;
                check_eq("sb_nonempty", (exp_q.size() != 0), 1);
                rx_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            end
            if (rx_busy) begin
                k = rx_pos / CPB;
                exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : rx_exp[k-1];
                if (bus_a.o_TX_Serial !== exp_bit) rx_wave_err++;
                if (bus_a.o_TX_Active === 1'b1) rx_act++;
                if ((rx_pos % CPB) == CPB/2 && k >= 1 && k <= 8) rx_byte[k-1] = bus_a.o_TX_Serial;
                if (rx_pos == FRAME - 1) begin
                    check_eq("rx_byte", rx_byte, rx_exp);
                    check_eq("wave_errors", rx_wave_err, 0);
                    check_eq("active_len", rx_act, FRAME);
                    rx_busy     = 1'b0;
                    rx_chk_done = 1'b1;
                    end_cyc     = cyc;
                    frames++;
                end
                rx_pos++;
            end
        end
    end

    task automatic push_a(input logic [7:0] b);
        bus_a.i_TX_DV   = 1'b1;
        bus_a.i_TX_Byte = b;
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int n = 0;
        while (frames < target && n < budget) begin
            @(negedge i_Clock);
            n++;
        end
        @(negedge i_Clock);
        #1;
        check_eq(tag, frames, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int push_cyc;
        int saved_done;
        int saved_frames;
        int lows;
        int n;
        int fall_cyc;
        int rise_cyc;

        bus_a.i_TX_DV = 1'b0; bus_a.i_TX_Byte = 8'h00;
        bus_b.i_TX_DV = 1'b0; bus_b.i_TX_Byte = 8'h00;
        repeat (3) @(negedge i_Clock);
        #1;
        check_eq("rst_serial", bus_a.o_TX_Serial, 1);
        check_eq("rst_active", bus_a.o_TX_Active, 0);
        check_eq("rst_done",   bus_a.o_TX_Done, 0);
        check_eq("rst_ready",  bus_a.o_TX_Ready, 1);
        check_eq("rst_serial_b", bus_b.o_TX_Serial, 1);
        i_Reset_n = 1'b1;
        repeat (2) @(negedge i_Clock);

        // Single byte: latency and done timing.
        @(negedge i_Clock); #1;
        push_cyc = cyc;
        exp_q.push_back(8'hA5);
        push_a(8'hA5);
        @(negedge i_Clock); #1;
        bus_a.i_TX_DV = 1'b0;
        wait_frames(1, 100, "frames_single");
        check_eq("start_latency", start_cyc - push_cyc, 2);
        check_eq("done_latency", last_done_cyc - push_cyc, 2 + FRAME);
        check_eq("done_count_1", done_pulses, 1);

        // Back-to-back frames.
        repeat (3) @(negedge i_Clock);
        #1;
        exp_q.push_back(8'h00); push_a(8'h00);
        @(negedge i_Clock); #1;
        exp_q.push_back(8'hFF); push_a(8'hFF);
        @(negedge i_Clock); #1;
        bus_a.i_TX_DV = 1'b0;
        wait_frames(3, 200, "frames_b2b");
        check_eq("b2b_gap", gap_last, 2);
        check_eq("done_count_3", done_pulses, 3);

        // FIFO full: 0x01..0x05 accepted, 0x06 dropped.
        repeat (3) @(negedge i_Clock);
        for (int i = 0; i < 6; i++) begin
            @(negedge i_Clock); #1;
            check_eq($sformatf("ready_fill_%0d", i), bus_a.o_TX_Ready, (i < 5));
            push_a(8'(i + 1));
            if (i < 5) exp_q.push_back(8'(i + 1));
        end
        @(negedge i_Clock); #1;
        bus_a.i_TX_DV = 1'b0;
        check_eq("ready_full", bus_a.o_TX_Ready, 0);

        // Push while full coinciding with the IDLE pop: dropped, occupancy drops by one.
        n = 0;
        while (bus_a.o_TX_Done !== 1'b1 && n < 100) begin
            @(negedge i_Clock);
            n++;
        end
        check_eq("wait_done_full", bus_a.o_TX_Done, 1);
        @(negedge i_Clock); #1;
        check_eq("ready_full_pop", bus_a.o_TX_Ready, 0);
        push_a(8'h77);
        @(negedge i_Clock); #1;
        bus_a.i_TX_DV = 1'b0;
        check_eq("ready_after_pop", bus_a.o_TX_Ready, 1);
        wait_frames(8, 400, "frames_full");
        repeat (50) @(negedge i_Clock);
        #1;
        check_eq("no_extra_frame", frames, 8);
        check_eq("done_count_8", done_pulses, 8);
        check_eq("sb_drained", exp_q.size(), 0);

        // Reset during DATA bit 3.
        @(negedge i_Clock); #1;
        push_cyc = cyc;
        exp_q.push_back(8'hF0);
        push_a(8'hF0);
        @(negedge i_Clock); #1;
        bus_a.i_TX_DV = 1'b0;
        n = 0;
        while (cyc < push_cyc + 19 && n < 50) begin
            @(negedge i_Clock);
            n++;
        end
        #1;
        check_eq("pre_rst_bit3", bus_a.o_TX_Serial, 0);
        check_eq("pre_rst_active", bus_a.o_TX_Active, 1);
        i_Reset_n = 1'b0;
        #1;
        check_eq("async_rst_serial", bus_a.o_TX_Serial, 1);
        check_eq("async_rst_active", bus_a.o_TX_Active, 0);
        check_eq("async_rst_ready", bus_a.o_TX_Ready, 1);
        exp_q.delete();
        saved_done   = done_pulses;
        saved_frames = frames;
        repeat (2) @(negedge i_Clock);
        #1;
        i_Reset_n = 1'b1;
        lows = 0;
        repeat (60) begin
            @(negedge i_Clock);
            if (bus_a.o_TX_Serial !== 1'b1) lows++;
        end
        #1;
        check_eq("post_rst_line_high", lows, 0);
        check_eq("post_rst_no_done", done_pulses, saved_done);
        check_eq("post_rst_no_frame", frames, saved_frames);
        check_eq("post_rst_ready", bus_a.o_TX_Ready, 1);

        // Full-rate timing: 0x3C puts start, bit0, bit1 low -> 3 bit times low.
        @(negedge i_Clock); #1;
        push_cyc = cyc;
        bus_b.i_TX_DV = 1'b1; bus_b.i_TX_Byte = 8'h3C;
        @(negedge i_Clock); #1;
        bus_b.i_TX_DV = 1'b0;
        n = 0;
        while (bus_b.o_TX_Serial !== 1'b0 && n < 10) begin
            @(negedge i_Clock); #1;
            n++;
        end
        fall_cyc = cyc;
        check_eq("big_start_latency", fall_cyc - push_cyc, 2);
        n = 0;
        while (bus_b.o_TX_Serial !== 1'b1 && n < 40000) begin
            @(negedge i_Clock); #1;
            n++;
        end
        rise_cyc = cyc;
        check_eq("big_low_run", rise_cyc - fall_cyc, 3 * CPB_BIG);
        check_eq("big_active", bus_b.o_TX_Active, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
